// File: rtl/grf_wb_arbiter.sv
// Arbitrates the single GRF write port between pipeline writeback (A) and a queued long-latency source (B); grant registered into grf_* one edge after request.
// B backpressure: b_ready = !full from registered occupancy; starved B head forces a 1-cycle stall_a drain. Optional trace: GRF_WB_TRACE_EN.
module grf_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       a_we,
  input  logic [4:0]                 a_wa,
  input  logic [31:0]                a_wd,
  input  logic [31:0]                a_pc,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [4:0]                 b_wa,
  input  logic [31:0]                b_wd,
  input  logic [31:0]                b_pc,
  input  logic [4:0]                 q_ra1,
  input  logic [4:0]                 q_ra2,
  output logic                       q_hit1,
  output logic                       q_hit2,
  output logic                       stall_a,
  output logic [$clog2(DEPTH+1)-1:0] b_count,
  output logic                       grf_we,
  output logic [4:0]                 grf_wa,
  output logic [31:0]                grf_wd,
  output logic [31:0]                grf_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {NORMAL, DRAIN} state_t;

  typedef struct packed {
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  ent_t          mem_q [DEPTH];
  ent_t          mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    starve_q, starve_d;
  state_t        state_q, state_d;
  logic          rdy_en_q;
  logic          grf_we_q, grf_we_d;
  logic          grf_isb_q, grf_isb_d;
  logic [4:0]    grf_wa_q, grf_wa_d;
  logic [31:0]   grf_wd_q, grf_wd_d;
  logic [31:0]   grf_pc_q, grf_pc_d;

  logic             full, empty, push, pop, a_req, grant_a;
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0]    off;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  // rdy_en_q keeps b_ready low through reset and raises it on the first edge after.
  assign b_ready = rdy_en_q && !full;
  assign push    = b_valid && b_ready && (b_wa != 5'd0);
  assign a_req   = a_we && (a_wa != 5'd0);

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    pop      = 1'b0;
    grant_a  = 1'b0;
    case (state_q)
      NORMAL: begin
        if (a_req) begin
          grant_a = 1'b1;
          if (!empty) starve_d = starve_q + 8'd1;
        end else if (!empty) begin
          pop      = 1'b1;
          starve_d = '0;
        end else begin
          starve_d = '0;
        end
        if (starve_d == 8'(STARVE_MAX)) state_d = DRAIN;
      end
      DRAIN: begin
        pop      = !empty;
        starve_d = '0;
        state_d  = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (push) mem_d[wr_ptr_q] = '{wa: b_wa, wd: b_wd, pc: b_pc};
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    grf_we_d  = grant_a || pop;
    grf_isb_d = grf_isb_q;
    grf_wa_d  = grf_wa_q;
    grf_wd_d  = grf_wd_q;
    grf_pc_d  = grf_pc_q;
    if (grant_a) begin
      grf_isb_d = 1'b0;
      grf_wa_d  = a_wa;
      grf_wd_d  = a_wd;
      grf_pc_d  = a_pc;
    end else if (pop) begin
      grf_isb_d = 1'b1;
      grf_wa_d  = mem_q[rd_ptr_q].wa;
      grf_wd_d  = mem_q[rd_ptr_q].wd;
      grf_pc_d  = mem_q[rd_ptr_q].pc;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    ent_vld = '0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = PW'(i) - rd_ptr_q;
      ent_vld[i] = (CW'(off) < count_q);
    end
  end

  function automatic logic pending(input logic [4:0] ra);
    logic hit;
    hit = grf_we_q && grf_isb_q && (grf_wa_q == ra);
    for (int i = 0; i < DEPTH; i++)
      if (ent_vld[i] && (mem_q[i].wa == ra)) hit = 1'b1;
    return hit && (ra != 5'd0);
  endfunction

  assign q_hit1  = pending(q_ra1);
  assign q_hit2  = pending(q_ra2);
  assign stall_a = (state_q == DRAIN);
  assign b_count = count_q;
  assign grf_we  = grf_we_q;
  assign grf_wa  = grf_wa_q;
  assign grf_wd  = grf_wd_q;
  assign grf_pc  = grf_pc_q;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      state_q   <= NORMAL;
      rdy_en_q  <= 1'b0;
      grf_we_q  <= 1'b0;
      grf_isb_q <= 1'b0;
      grf_wa_q  <= '0;
      grf_wd_q  <= '0;
      grf_pc_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      state_q   <= state_d;
      rdy_en_q  <= 1'b1;
      grf_we_q  <= grf_we_d;
      grf_isb_q <= grf_isb_d;
      grf_wa_q  <= grf_wa_d;
      grf_wd_q  <= grf_wd_d;
      grf_pc_q  <= grf_pc_d;
    end
  end

`ifdef GRF_WB_TRACE_EN
  always @(posedge clk) begin
    if (!Reset && grf_we_q) $display("@%h: $%d <= %h", grf_pc_q, grf_wa_q, grf_wd_q);
    if (!Reset && grant_a && pending(a_wa))
      $display("warning: A write to $%0d while a B write to it is pending", a_wa);
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule
